mfcc_frame_sequencer: RTL and testbench

- Central controller for the MFCC datapath. Sequences each frame through the four stages in order: Hamming window, FFT, Mel filterbank, DCT.
- Each stage gets a one-cycle start pulse; the sequencer then waits for that stage's done pulse before moving on.
- Triggered by the window buffer's frame-ready pulse. Buffers one pending frame, flags overruns and stage timeouts, and counts completed frames.

---
 rtl/mfcc_frame_sequencer_if.sv | 37 +++
 rtl/mfcc_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mfcc_frame_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_frame_sequencer_if.sv
// Control bus between the MFCC frame sequencer, the window buffer and the four stage engines.
interface mfcc_frame_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 enable_i;
    logic                 frame_ready_i;
    logic                 hamming_start_o;
    logic                 hamming_done_i;
    logic                 fft_start_o;
    logic                 fft_done_i;
    logic                 mel_start_o;
    logic                 mel_done_i;
    logic                 dct_start_o;
    logic                 dct_done_i;
    logic                 busy_o;
    logic [2:0]           stage_o;
    logic                 frame_done_o;
    logic [CNT_WIDTH-1:0] frame_count_o;
    logic                 overrun_o;
    logic                 timeout_o;
    logic                 clear_flags_i;
    logic [31:0]          last_frame_cycles_o;

    modport master (
        input  enable_i, frame_ready_i, hamming_done_i, fft_done_i, mel_done_i, dct_done_i,
               clear_flags_i,
        output hamming_start_o, fft_start_o, mel_start_o, dct_start_o, busy_o, stage_o,
               frame_done_o, frame_count_o, overrun_o, timeout_o, last_frame_cycles_o
    );

    modport slave (
        output enable_i, frame_ready_i, hamming_done_i, fft_done_i, mel_done_i, dct_done_i,
               clear_flags_i,
        input  hamming_start_o, fft_start_o, mel_start_o, dct_start_o, busy_o, stage_o,
               frame_done_o, frame_count_o, overrun_o, timeout_o, last_frame_cycles_o
    );
endinterface

// File: rtl/mfcc_frame_sequencer.sv
// MFCC frame sequencer: runs each frame through Hamming, FFT, Mel and DCT with a per-stage watchdog.
// Define MFCC_SEQ_PROFILE_EN to measure the busy cycles of each completed frame.
module mfcc_frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input logic                    clk,
    input logic                    rst,
    mfcc_frame_sequencer_if.master bus
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HAM    = 3'd1,
        S_FFT    = 3'd2,
        S_MEL    = 3'd3,
        S_DCT    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 pending_q, pending_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 ham_start_q, ham_start_d;
    logic                 fft_start_q, fft_start_d;
    logic                 mel_start_q, mel_start_d;
    logic                 dct_start_q, dct_start_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic                 stage_done, expired, dispatch, overrun_set, timeout_set;

    always_comb begin
        case (state_q)
            S_HAM:   stage_done = bus.hamming_done_i;
            S_FFT:   stage_done = bus.fft_done_i;
            S_MEL:   stage_done = bus.mel_done_i;
            S_DCT:   stage_done = bus.dct_done_i;
            default: stage_done = 1'b0;
        endcase
        expired  = (wd_q == WD_LAST);
        dispatch = (state_q == S_IDLE) && bus.enable_i && (bus.frame_ready_i || pending_q);

        state_d      = state_q;
        wd_d         = '0;
        ham_start_d  = 1'b0;
        fft_start_d  = 1'b0;
        mel_start_d  = 1'b0;
        dct_start_d  = 1'b0;
        frame_done_d = 1'b0;
        count_d      = count_q;
        timeout_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dispatch) begin
                    state_d     = S_HAM;
                    ham_start_d = 1'b1;
                end
            end
            S_HAM, S_FFT, S_MEL, S_DCT: begin
                wd_d = wd_q + 1'b1;
                // A done arriving on the expiry cycle still advances normally.
                if (stage_done) begin
                    wd_d = '0;
                    case (state_q)
                        S_HAM: begin state_d = S_FFT; fft_start_d = 1'b1; end
                        S_FFT: begin state_d = S_MEL; mel_start_d = 1'b1; end
                        S_MEL: begin state_d = S_DCT; dct_start_d = 1'b1; end
                        default: begin
                            state_d      = S_FINISH;
                            frame_done_d = 1'b1;
                            count_d      = count_q + 1'b1;
                        end
                    endcase
                end else if (expired) begin
                    wd_d        = '0;
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One frame may wait in reserve; a further arrival is dropped.
        pending_d   = pending_q;
        overrun_set = 1'b0;
        if (dispatch) begin
            pending_d = pending_q && bus.frame_ready_i;
        end else if (bus.frame_ready_i) begin
            if (pending_q) overrun_set = 1'b1;
            else           pending_d   = 1'b1;
        end
        overrun_d = bus.clear_flags_i ? 1'b0 : (overrun_q | overrun_set);
        timeout_d = bus.clear_flags_i ? 1'b0 : (timeout_q | timeout_set);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            wd_q         <= '0;
            ham_start_q  <= 1'b0;
            fft_start_q  <= 1'b0;
            mel_start_q  <= 1'b0;
            dct_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            wd_q         <= wd_d;
            ham_start_q  <= ham_start_d;
            fft_start_q  <= fft_start_d;
            mel_start_q  <= mel_start_d;
            dct_start_q  <= dct_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.hamming_start_o = ham_start_q;
    assign bus.fft_start_o     = fft_start_q;
    assign bus.mel_start_o     = mel_start_q;
    assign bus.dct_start_o     = dct_start_q;
    assign bus.busy_o          = busy_q;
    assign bus.stage_o         = state_q;
    assign bus.frame_done_o    = frame_done_q;
    assign bus.frame_count_o   = count_q;
    assign bus.overrun_o       = overrun_q;
    assign bus.timeout_o       = timeout_q;

`ifdef MFCC_SEQ_PROFILE_EN
    logic [31:0] cyc_q, cyc_d, last_cycles_q, last_cycles_d;

    // The FINISH cycle itself is included in the reported frame length.
    always_comb begin
        cyc_d         = cyc_q;
        last_cycles_d = last_cycles_q;
        if (dispatch)                cyc_d = '0;
        else if (state_q != S_IDLE)  cyc_d = cyc_q + 32'd1;
        if (state_q == S_FINISH)     last_cycles_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q         <= '0;
            last_cycles_q <= '0;
        end else begin
            cyc_q         <= cyc_d;
            last_cycles_q <= last_cycles_d;
        end
    end

    assign bus.last_frame_cycles_o = last_cycles_q;
`else
    assign bus.last_frame_cycles_o = 32'd0;
`endif
endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Bench for mfcc_frame_sequencer: scenario table with a stage-responder model, a frame
// scoreboard, and hand-written sequences for stray done, enable drop, flag clear and reset.
`timescale 1ns/1ps
module tb_mfcc_frame_sequencer;
    localparam int TMO = 16;
    localparam int CW  = 16;
    localparam int RUN = 70;
    localparam int NV  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mfcc_frame_sequencer_if #(.CNT_WIDTH(CW)) bus ();
    mfcc_frame_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        int       d_ham, d_fft, d_mel, d_dct;  // done latency after start, 0 = never
        int       r0, r1, r2;                  // frame_ready offsets, -1 = unused
        bit [2:0] completes;                   // which ready pulses yield a finished frame
        int       exp_ham1, exp_fft1, exp_end, exp_ham2;
        bit       exp_ovr, exp_tmo;
        int       exp_last;
    } vec_t;

    vec_t          vecs [NV];
    int            checks = 0;
    int            failures = 0;
    int            off;
    int            first_ham, second_ham, first_fft, first_end;
    int            dly [4];
    int            rcnt [4];
    logic [CW-1:0] model_cnt;
    logic [CW-1:0] sb [$];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_frame();
        model_cnt = model_cnt + 1'b1;
        sb.push_back(model_cnt);
    endtask

    task automatic mon_reset();
        off = -1;
        first_ham = -1; second_ham = -1; first_fft = -1; first_end = -1;
        foreach (rcnt[i]) rcnt[i] = 0;
    endtask

    // Advance to the next falling edge, observe outputs, model the stage engines.
    task automatic tick();
        logic [3:0] starts;
        logic [3:0] dones;
        @(negedge clk);
        off++;
        bus.frame_ready_i = 1'b0;
        bus.clear_flags_i = 1'b0;
        if (bus.hamming_start_o) begin
            if (first_ham < 0) first_ham = off;
            else if (second_ham < 0) second_ham = off;
        end
        if (bus.fft_start_o && first_fft < 0) first_fft = off;
        if (first_ham >= 0 && off > first_ham && !bus.busy_o && first_end < 0) first_end = off;
        if (bus.frame_done_o) begin
            chk("frame_done_expected", sb.size(), (sb.size() > 0) ? sb.size() : 1);
            if (sb.size() > 0) chk("frame_count_at_done", bus.frame_count_o, sb.pop_front());
        end
        starts = {bus.dct_start_o, bus.mel_start_o, bus.fft_start_o, bus.hamming_start_o};
        dones  = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (rcnt[i] > 0) begin
                rcnt[i]--;
                if (rcnt[i] == 0) dones[i] = 1'b1;
            end
            if (starts[i]) rcnt[i] = dly[i];
        end
        bus.hamming_done_i = dones[0];
        bus.fft_done_i     = dones[1];
        bus.mel_done_i     = dones[2];
        bus.dct_done_i     = dones[3];
    endtask

    function automatic logic [58:0] all_outs();
        return {bus.hamming_start_o, bus.fft_start_o, bus.mel_start_o, bus.dct_start_o,
                bus.busy_o, bus.stage_o, bus.frame_done_o, bus.frame_count_o,
                bus.overrun_o, bus.timeout_o, bus.last_frame_cycles_o};
    endfunction

    initial begin
        int exp_last;
        //           dH dF dM dD  r0  r1  r2  cmp     ham1 fft1 end ham2 ovr tmo last
        vecs[0] = '{ 5, 5, 5, 5,  10, -1, -1, 3'b001, 11,  17,  36, -1,  0,  0,  25 };
        vecs[1] = '{ 5, 5, 5, 5,   1, 10, -1, 3'b011,  2,   8,  27, 28,  0,  0,  25 };
        vecs[2] = '{ 5, 5, 5, 5,   1,  5,  9, 3'b011,  2,   8,  27, 28,  1,  0,  25 };
        vecs[3] = '{ 5, 5, 0, 5,   1, -1, -1, 3'b000,  2,   8,  30, -1,  0,  1,  25 };
        vecs[4] = '{ 1, 3, 2, 7,   1, -1, -1, 3'b001,  2,   4,  20, -1,  0,  0,  18 };
        vecs[5] = '{15, 1, 1, 1,   1, -1, -1, 3'b001,  2,  18,  25, -1,  0,  0,  23 };
        vecs[6] = '{16, 5, 5, 5,   1, -1, -1, 3'b000,  2,  -1,  18, -1,  0,  1,  23 };
        vecs[7] = '{ 2, 2, 2, 2,   1, -1, -1, 3'b001,  2,   5,  15, -1,  0,  0,  13 };

        rst = 1'b1;
        bus.enable_i = 1'b1;
        bus.frame_ready_i = 1'b0;
        bus.clear_flags_i = 1'b0;
        bus.hamming_done_i = 1'b0;
        bus.fft_done_i = 1'b0;
        bus.mel_done_i = 1'b0;
        bus.dct_done_i = 1'b0;
        model_cnt = '0;
        dly = '{5, 5, 5, 5};
        mon_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        tick();
        chk("post_reset_outputs", all_outs(), 0);

        for (int v = 0; v < NV; v++) begin
            dly = '{vecs[v].d_ham, vecs[v].d_fft, vecs[v].d_mel, vecs[v].d_dct};
            mon_reset();
            for (int k = 0; k < RUN; k++) begin
                tick();
                if (k == vecs[v].r0 || k == vecs[v].r1 || k == vecs[v].r2) begin
                    bus.frame_ready_i = 1'b1;
                    if ((k == vecs[v].r0 && vecs[v].completes[0]) ||
                        (k == vecs[v].r1 && vecs[v].completes[1]) ||
                        (k == vecs[v].r2 && vecs[v].completes[2])) push_frame();
                end
            end
`ifdef MFCC_SEQ_PROFILE_EN
            exp_last = vecs[v].exp_last;
`else
            exp_last = 0;
`endif
            chk($sformatf("v%0d_ham_start1", v), first_ham, vecs[v].exp_ham1);
            chk($sformatf("v%0d_fft_start1", v), first_fft, vecs[v].exp_fft1);
            chk($sformatf("v%0d_idle_at", v), first_end, vecs[v].exp_end);
            chk($sformatf("v%0d_ham_start2", v), second_ham, vecs[v].exp_ham2);
            chk($sformatf("v%0d_overrun", v), bus.overrun_o, vecs[v].exp_ovr);
            chk($sformatf("v%0d_timeout", v), bus.timeout_o, vecs[v].exp_tmo);
            chk($sformatf("v%0d_busy_end", v), bus.busy_o, 0);
            chk($sformatf("v%0d_frame_count", v), bus.frame_count_o, model_cnt);
            chk($sformatf("v%0d_sb_drained", v), sb.size(), 0);
            chk($sformatf("v%0d_last_cycles", v), bus.last_frame_cycles_o, exp_last);
            tick();
            bus.clear_flags_i = 1'b1;
            tick();
            chk($sformatf("v%0d_flags_cleared", v), {bus.overrun_o, bus.timeout_o}, 0);
        end

        // Stray done pulses from inactive stages while in HAM.
        dly = '{5, 5, 5, 5};
        mon_reset();
        tick(); bus.frame_ready_i = 1'b1; push_frame();
        tick();
        tick(); bus.fft_done_i = 1'b1; bus.dct_done_i = 1'b1;
        tick();
        chk("stray_stage_ham", bus.stage_o, 1);
        chk("stray_no_fft_start", bus.fft_start_o, 0);
        repeat (40) tick();
        chk("stray_frame_count", bus.frame_count_o, model_cnt);

        // enable_i drop in MEL: frame completes, later frame waits as pending.
        mon_reset();
        tick(); bus.frame_ready_i = 1'b1; push_frame();
        repeat (13) tick();
        chk("en_stage_mel", bus.stage_o, 3);
        bus.enable_i = 1'b0;
        repeat (17) tick();
        chk("en_frame_completed", bus.frame_count_o, model_cnt);
        chk("en_idle_after", bus.busy_o, 0);
        bus.frame_ready_i = 1'b1; push_frame();
        repeat (4) tick();
        chk("en_held_idle", bus.busy_o, 0);
        bus.enable_i = 1'b1;
        repeat (36) tick();
        chk("en_pending_start", second_ham, 35);
        chk("en_frame_count", bus.frame_count_o, model_cnt);
        chk("en_sb_drained", sb.size(), 0);

        // clear_flags_i wins over an overrun raised in the same cycle.
        mon_reset();
        tick(); bus.frame_ready_i = 1'b1; push_frame();
        repeat (4) tick(); bus.frame_ready_i = 1'b1; push_frame();
        repeat (4) tick(); bus.frame_ready_i = 1'b1; bus.clear_flags_i = 1'b1;
        tick();
        chk("clr_priority_overrun", bus.overrun_o, 0);
        bus.frame_ready_i = 1'b1;
        tick();
        chk("clr_then_overrun", bus.overrun_o, 1);
        repeat (60) tick();
        chk("clr_frame_count", bus.frame_count_o, model_cnt);
        chk("clr_sb_drained", sb.size(), 0);
        bus.clear_flags_i = 1'b1;
        tick();
        tick();
        chk("clr_overrun_cleared", bus.overrun_o, 0);

        // Reset while in DCT with a frame pending.
        mon_reset();
        tick(); bus.frame_ready_i = 1'b1; push_frame();
        repeat (5) tick(); bus.frame_ready_i = 1'b1;
        repeat (15) tick();
        chk("rst_stage_dct", bus.stage_o, 4);
        #1 rst = 1'b1;
        #1 chk("rst_mid_outputs", all_outs(), 0);
        model_cnt = '0;
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_pending_lost", bus.busy_o, 0);
        chk("rst_count_zero", bus.frame_count_o, 0);
        bus.frame_ready_i = 1'b1; push_frame();
        repeat (35) tick();
        chk("rst_next_frame_count", bus.frame_count_o, model_cnt);
        chk("rst_sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation still running at %0t, limit 1000000", $time);
        $fatal(1);
    end
endmodule
